mmio_fabric: RTL and testbench

//  Parametrised memory-mapped I/O interconnect between the MIPS CPU data port and
//  NUM_SLAVES peripherals (data RAM, VGA screen RAM, keyboard, timers, ...).

---
 rtl/mmio_fabric_pkg.sv | 23 ++
 rtl/mmio_timeout_ctr.sv | 45 ++++
 rtl/mmio_fabric.sv | 169 ++++++++++++++++
 tb/tb_mmio_fabric.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_fabric_pkg.sv
// Shared definitions for the MMIO fabric: FSM state codes, default error data
// and the slave index map of the standard system.
package mmio_fabric_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEADBEEF;

  localparam int SL_DMEM = 0;
  localparam int SL_VGA  = 1;
  localparam int SL_KBD  = 2;
  localparam int SL_TMR  = 3;

  // Counter width able to hold 0..timeout; never narrower than one bit.
  function automatic int cnt_width(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mmio_timeout_ctr.sv
// Slave-response watchdog: counts enabled cycles and flags the last one allowed.
// With TIMEOUT=0 the watchdog is absent and never expires.
module mmio_timeout_ctr
  import mmio_fabric_pkg::*;
#(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = cnt_width(TIMEOUT);

  generate
    if (TIMEOUT == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = ^{clk, rst, clr, en};
      assign expire        = 1'b0;
    end else begin : g_on
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (clr)     cnt_d = '0;
        else if (en) cnt_d = cnt_q + CW'(1);
      end

      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values of its neighbours.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
      end

      assign expire = en && (cnt_q == LAST);
    end
  endgenerate

endmodule

// File: rtl/mmio_fabric.sv
// CPU data-port interconnect: decodes the region field, runs req/ack with one
// slave at a time and turns unmapped or silent slaves into error responses.
module mmio_fabric
  import mmio_fabric_pkg::*;
#(
  parameter int              AW         = 32,
  parameter int              DW         = 32,
  parameter int              NUM_SLAVES = 4,
  parameter int              SEL_W      = 2,
  parameter int              SEL_LSB    = 28,
  parameter int              TIMEOUT    = 256,
  parameter logic [DW-1:0]   ERR_RDATA  = DW'(ERR_RDATA_DEFAULT)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [AW-1:0]            cpu_addr,
  input  logic [DW-1:0]            cpu_wdata,
  output logic [DW-1:0]            cpu_rdata,
  output logic                     cpu_ready,
  output logic [NUM_SLAVES-1:0]    s_req,
  output logic                     s_we,
  output logic [AW-1:0]            s_addr,
  output logic [DW-1:0]            s_wdata,
  input  logic [NUM_SLAVES*DW-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]    s_ack,
  input  logic                     err_clr,
  output logic                     err_irq,
  output logic [AW-1:0]            err_addr
);

  state_e                  state_q, state_d;
  logic                    we_q, we_d;
  logic [AW-1:0]           addr_q, addr_d;
  logic [DW-1:0]           wdata_q, wdata_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [NUM_SLAVES-1:0]   s_req_q, s_req_d;
  logic [DW-1:0]           rdata_q, rdata_d;
  logic                    err_irq_q, err_irq_d;
  logic [AW-1:0]           err_addr_q, err_addr_d;

  logic [SEL_W-1:0]        sel_in;
  logic                    mapped_in;
  logic                    ack_hit;
  logic                    expire;
  logic                    err_evt;
  logic [AW-1:0]           err_evt_addr;
  logic [DW-1:0]           slave_rdata;

  assign sel_in    = cpu_addr[SEL_LSB +: SEL_W];
  assign mapped_in = (int'(sel_in) < NUM_SLAVES);
  // s_req is one-hot on sel_q, so masking with it ignores acks from other slaves.
  assign ack_hit   = |(s_ack & s_req_q);

  always_comb begin
    slave_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q == SEL_W'(i)) slave_rdata = s_rdata[i*DW +: DW];
    end
  end

  mmio_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q != ST_BUSY),
    .en     (state_q == ST_BUSY),
    .expire (expire)
  );

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    sel_d        = sel_q;
    s_req_d      = s_req_q;
    rdata_d      = rdata_q;
    err_evt      = 1'b0;
    err_evt_addr = addr_q;

    case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          we_d    = cpu_we;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          sel_d   = sel_in;
          if (mapped_in) begin
            state_d = ST_BUSY;
            for (int i = 0; i < NUM_SLAVES; i++) s_req_d[i] = (sel_in == SEL_W'(i));
          end else begin
            state_d      = ST_RESP;
            err_evt      = 1'b1;
            err_evt_addr = cpu_addr;
            if (!cpu_we) rdata_d = ERR_RDATA;
          end
        end
      end
      ST_BUSY: begin
        // An ack arriving on the expiry cycle still completes normally.
        if (ack_hit) begin
          s_req_d = '0;
          state_d = ST_RESP;
          if (!we_q) rdata_d = slave_rdata;
        end else if (expire) begin
          s_req_d = '0;
          state_d = ST_RESP;
          err_evt = 1'b1;
          if (!we_q) rdata_d = ERR_RDATA;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        s_req_d = '0;
      end
    endcase

    // A new error beats a simultaneous clear and reloads the address.
    err_irq_d  = err_irq_q;
    err_addr_d = err_addr_q;
    if (err_evt) begin
      err_irq_d = 1'b1;
      if (!err_irq_q || err_clr) err_addr_d = err_evt_addr;
    end else if (err_clr) begin
      err_irq_d  = 1'b0;
      err_addr_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      sel_q      <= '0;
      s_req_q    <= '0;
      rdata_q    <= '0;
      err_irq_q  <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      sel_q      <= sel_d;
      s_req_q    <= s_req_d;
      rdata_q    <= rdata_d;
      err_irq_q  <= err_irq_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign cpu_ready = (state_q == ST_RESP);
  assign cpu_rdata = rdata_q;
  assign s_req     = s_req_q;
  assign s_we      = we_q;
  assign s_addr    = addr_q;
  assign s_wdata   = wdata_q;
  assign err_irq   = err_irq_q;
  assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_mmio_fabric.sv
// Directed bench for mmio_fabric: three mapped slaves, region 3 unmapped,
// an 8-cycle watchdog, with hand-computed expectations per scenario.
module tb_mmio_fabric;
  import mmio_fabric_pkg::*;

  localparam int NS = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req;
  logic          cpu_we;
  logic [31:0]   cpu_addr;
  logic [31:0]   cpu_wdata;
  logic [31:0]   cpu_rdata;
  logic          cpu_ready;
  logic [NS-1:0] s_req;
  logic          s_we;
  logic [31:0]   s_addr;
  logic [31:0]   s_wdata;
  logic [NS*32-1:0] s_rdata;
  logic [NS-1:0] s_ack;
  logic          err_clr;
  logic          err_irq;
  logic [31:0]   err_addr;

  int vectors     = 0;
  int miscompares = 0;

  mmio_fabric #(
    .AW(32), .DW(32), .NUM_SLAVES(NS), .SEL_W(2), .SEL_LSB(28),
    .TIMEOUT(8), .ERR_RDATA(32'hDEADBEEF)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ack(s_ack),
    .err_clr(err_clr), .err_irq(err_irq), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
    $fatal(1, "watchdog expired");
  end

  // Drives one access from IDLE and observes it at negedges until cpu_ready.
  task automatic run_access(
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  int          ack_slave,
    input  int          ack_after,
    input  logic [NS-1:0] noise,
    input  bit          clr_at_start,
    output int          req_cycles,
    output int          ready_at,
    output logic [NS-1:0] first_sreq,
    output logic        we_seen,
    output logic [31:0] addr_seen,
    output logic [31:0] wdata_seen,
    output bit          stable,
    output bit          onehot_ok,
    output logic [31:0] rdata,
    output logic        ready_after
  );
    req_cycles = 0; ready_at = -1; first_sreq = '0; we_seen = 1'b0;
    addr_seen = '0; wdata_seen = '0; stable = 1'b1; onehot_ok = 1'b1; rdata = '0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    err_clr = clr_at_start; s_ack = noise;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      err_clr = 1'b0;
      if (!$onehot0(s_req)) onehot_ok = 1'b0;
      if (s_req != '0) begin
        req_cycles++;
        if (req_cycles == 1) begin
          first_sreq = s_req; we_seen = s_we; addr_seen = s_addr; wdata_seen = s_wdata;
        end else if (s_req !== first_sreq || s_we !== we_seen ||
                     s_addr !== addr_seen || s_wdata !== wdata_seen) begin
          stable = 1'b0;
        end
      end
      if (cpu_ready) begin
        ready_at = cyc;
        rdata    = cpu_rdata;
        if (s_req != '0) onehot_ok = 1'b0;
        break;
      end
      s_ack = noise;
      if (s_req != '0 && req_cycles == ack_after) s_ack[ack_slave] = 1'b1;
    end
    cpu_req = 1'b0; s_ack = '0; err_clr = 1'b0;
    @(negedge clk);
    ready_after = cpu_ready;
  endtask

  task automatic test_reset();
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    s_ack = '0; err_clr = 1'b0;
    s_rdata = {32'h2222_2222, 32'h1234_5678, 32'h0BAD_F00D};
    @(negedge clk); @(negedge clk);
    vectors++; if ({cpu_ready, s_req, s_we, err_irq} !== '0) begin miscompares++;
      $display("FAIL rst_ctrl: got ready/req/we/irq=%b want 0", {cpu_ready, s_req, s_we, err_irq}); end
    vectors++; if ({cpu_rdata, s_addr, s_wdata, err_addr} !== '0) begin miscompares++;
      $display("FAIL rst_data: got rdata=%h addr=%h wdata=%h eaddr=%h want 0", cpu_rdata, s_addr, s_wdata, err_addr); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read();
    int rc, ra; logic [NS-1:0] fs; logic ws, rdy; logic [31:0] as, wsd, rd; bit st, oh;
    run_access(1'b0, 32'h1000_0040, 32'h0, SL_VGA, 3, '0, 1'b0, rc, ra, fs, ws, as, wsd, st, oh, rd, rdy);
    vectors++; if (rc !== 3) begin miscompares++; $display("FAIL rd_req_cycles: got %0d want 3", rc); end
    vectors++; if (fs !== 3'b010) begin miscompares++; $display("FAIL rd_sreq: got %b want 010", fs); end
    vectors++; if (ra !== 4) begin miscompares++; $display("FAIL rd_latency: got %0d want 4", ra); end
    vectors++; if (rd !== 32'h1234_5678) begin miscompares++; $display("FAIL rd_data: got %h want 12345678", rd); end
    vectors++; if ({ws, as} !== {1'b0, 32'h1000_0040}) begin miscompares++; $display("FAIL rd_shared: got we=%b addr=%h want 0/10000040", ws, as); end
    vectors++; if (!(st && oh)) begin miscompares++; $display("FAIL rd_stable: got stable=%0d onehot=%0d want 1/1", st, oh); end
    vectors++; if (rdy !== 1'b0) begin miscompares++; $display("FAIL rd_ready_pulse: got %b want 0 after completion", rdy); end
    vectors++; if (err_irq !== 1'b0) begin miscompares++; $display("FAIL rd_no_err: got %b want 0", err_irq); end
  endtask

  task automatic test_write();
    int rc, ra; logic [NS-1:0] fs; logic ws, rdy; logic [31:0] as, wsd, rd; bit st, oh;
    run_access(1'b1, 32'h0000_0020, 32'hCAFE_F00D, SL_DMEM, 1, '0, 1'b0, rc, ra, fs, ws, as, wsd, st, oh, rd, rdy);
    vectors++; if ({rc, ra} !== {32'd1, 32'd2}) begin miscompares++; $display("FAIL wr_timing: got req=%0d ready=%0d want 1/2", rc, ra); end
    vectors++; if ({fs, ws} !== {3'b001, 1'b1}) begin miscompares++; $display("FAIL wr_sreq_we: got %b/%b want 001/1", fs, ws); end
    vectors++; if ({as, wsd} !== {32'h0000_0020, 32'hCAFE_F00D}) begin miscompares++; $display("FAIL wr_addr_data: got %h/%h want 00000020/cafef00d", as, wsd); end
    vectors++; if (rd !== 32'h1234_5678) begin miscompares++; $display("FAIL wr_rdata_kept: got %h want 12345678", rd); end
  endtask

  task automatic test_unmapped();
    int rc, ra; logic [NS-1:0] fs; logic ws, rdy; logic [31:0] as, wsd, rd; bit st, oh;
    run_access(1'b0, 32'h3000_0000, 32'h0, 0, -1, '0, 1'b0, rc, ra, fs, ws, as, wsd, st, oh, rd, rdy);
    vectors++; if ({rc, ra} !== {32'd0, 32'd1}) begin miscompares++; $display("FAIL um_timing: got req=%0d ready=%0d want 0/1", rc, ra); end
    vectors++; if (rd !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL um_rdata: got %h want deadbeef", rd); end
    vectors++; if ({err_irq, err_addr} !== {1'b1, 32'h3000_0000}) begin miscompares++; $display("FAIL um_err: got irq=%b addr=%h want 1/30000000", err_irq, err_addr); end
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    vectors++; if ({err_irq, err_addr} !== '0) begin miscompares++; $display("FAIL um_clr: got irq=%b addr=%h want 0/0", err_irq, err_addr); end
  endtask

  task automatic test_timeout();
    int rc, ra; logic [NS-1:0] fs; logic ws, rdy; logic [31:0] as, wsd, rd; bit st, oh;
    run_access(1'b0, 32'h2000_0010, 32'h0, SL_KBD, -1, '0, 1'b0, rc, ra, fs, ws, as, wsd, st, oh, rd, rdy);
    vectors++; if ({rc, ra} !== {32'd8, 32'd9}) begin miscompares++; $display("FAIL to_timing: got req=%0d ready=%0d want 8/9", rc, ra); end
    vectors++; if ({fs, st} !== {3'b100, 1'b1}) begin miscompares++; $display("FAIL to_sreq: got %b stable=%0d want 100/1", fs, st); end
    vectors++; if (rd !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL to_rdata: got %h want deadbeef", rd); end
    vectors++; if ({err_irq, err_addr} !== {1'b1, 32'h2000_0010}) begin miscompares++; $display("FAIL to_err: got irq=%b addr=%h want 1/20000010", err_irq, err_addr); end
    run_access(1'b1, 32'h3000_0004, 32'h5, 0, -1, '0, 1'b0, rc, ra, fs, ws, as, wsd, st, oh, rd, rdy);
    vectors++; if ({err_irq, err_addr} !== {1'b1, 32'h2000_0010}) begin miscompares++; $display("FAIL to_second_err: got irq=%b addr=%h want 1/20000010", err_irq, err_addr); end
    run_access(1'b0, 32'h3000_0008, 32'h0, 0, -1, '0, 1'b1, rc, ra, fs, ws, as, wsd, st, oh, rd, rdy);
    vectors++; if ({err_irq, err_addr} !== {1'b1, 32'h3000_0008}) begin miscompares++; $display("FAIL to_clr_and_err: got irq=%b addr=%h want 1/30000008", err_irq, err_addr); end
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    vectors++; if ({err_irq, err_addr} !== '0) begin miscompares++; $display("FAIL to_clr: got irq=%b addr=%h want 0/0", err_irq, err_addr); end
  endtask

  task automatic test_spurious_ack();
    int rc, ra; logic [NS-1:0] fs; logic ws, rdy; logic [31:0] as, wsd, rd; bit st, oh;
    logic quiet;
    quiet = 1'b1;
    s_ack = 3'b111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (cpu_ready !== 1'b0 || s_req !== '0) quiet = 1'b0;
    end
    s_ack = '0;
    vectors++; if (quiet !== 1'b1) begin miscompares++; $display("FAIL sp_idle: got quiet=%b want 1", quiet); end
    run_access(1'b0, 32'h0000_0100, 32'h0, SL_DMEM, 2, 3'b110, 1'b0, rc, ra, fs, ws, as, wsd, st, oh, rd, rdy);
    vectors++; if ({rc, ra} !== {32'd2, 32'd3}) begin miscompares++; $display("FAIL sp_timing: got req=%0d ready=%0d want 2/3", rc, ra); end
    vectors++; if (rd !== 32'h0BAD_F00D) begin miscompares++; $display("FAIL sp_rdata: got %h want 0badf00d", rd); end
    vectors++; if ({oh, fs} !== {1'b1, 3'b001}) begin miscompares++; $display("FAIL sp_onehot: got onehot=%0d sreq=%b want 1/001", oh, fs); end
    vectors++; if (err_irq !== 1'b0) begin miscompares++; $display("FAIL sp_no_err: got %b want 0", err_irq); end
  endtask

  task automatic test_async_reset();
    logic ok_after;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1000_0000;
    @(negedge clk);
    vectors++; if (s_req !== 3'b010) begin miscompares++; $display("FAIL ar_busy: got %b want 010", s_req); end
    #2 rst = 1'b1;
    #1;
    vectors++; if ({s_req, cpu_ready, s_we, s_addr} !== '0) begin miscompares++;
      $display("FAIL ar_drop: got req=%b ready=%b addr=%h want 0", s_req, cpu_ready, s_addr); end
    cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    ok_after = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (cpu_ready !== 1'b0 || s_req !== '0) ok_after = 1'b0;
    end
    vectors++; if (ok_after !== 1'b1) begin miscompares++; $display("FAIL ar_no_resp: got ok=%b want 1", ok_after); end
  endtask

  task automatic test_back_to_back();
    int n_ready, r1_at, r2_at;
    logic [31:0] d1, d2;
    n_ready = 0; r1_at = -1; r2_at = -1; d1 = '0; d2 = '0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0004;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      s_ack = s_req;
      if (cpu_ready) begin
        n_ready++;
        if (n_ready == 1) begin
          r1_at = cyc; d1 = cpu_rdata; cpu_addr = 32'h2000_0008;
        end else begin
          r2_at = cyc; d2 = cpu_rdata; break;
        end
      end
    end
    cpu_req = 1'b0; s_ack = '0;
    vectors++; if ({r1_at, r2_at} !== {32'd2, 32'd5}) begin miscompares++; $display("FAIL b2b_timing: got %0d/%0d want 2/5", r1_at, r2_at); end
    vectors++; if ({d1, d2} !== {32'h0BAD_F00D, 32'h2222_2222}) begin miscompares++; $display("FAIL b2b_data: got %h/%h want 0badf00d/22222222", d1, d2); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_unmapped();
    test_timeout();
    test_spurious_ack();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
